// File: rtl/issue_scoreboard_pkg.sv
// Shared defaults and ring-entry layout for the issue scoreboard and its writeback ring.
package issue_scoreboard_pkg;

  localparam int unsigned AluLatDef  = 3;
  localparam int unsigned MulLatDef  = 6;
  localparam int unsigned RegAddrDef = 5;
  localparam int unsigned CntWDef    = 16;

  // Wide enough for any latency up to 15.
  localparam int unsigned LatW = 4;

  // Ring entry packing, MSB first: {valid, dst, is_mult}.
  function automatic int unsigned ring_entry_w(int unsigned reg_addr);
    return reg_addr + 2;
  endfunction

  localparam int unsigned RingEntryW = RegAddrDef + 2;

endpackage

// File: rtl/wb_reservation_ring.sv
// Writeback reservation ring: index k holds the entry that owns the write port k cycles from now.
module wb_reservation_ring
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned Depth  = MulLatDef,
  parameter int unsigned EntryW = RingEntryW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [LatW-1:0]   lat,
  input  logic [EntryW-1:0] push_entry,
  output logic              occupied,
  output logic [EntryW-1:0] head
);

  logic [Depth-1:0][EntryW-1:0] ring_q, ring_d;

  always_comb begin
    // A slot Depth cycles out can never be taken yet, so only indices below Depth are searched.
    occupied = 1'b0;
    for (int unsigned k = 1; k < Depth; k++) begin
      if (32'(lat) == k) occupied = ring_q[k][EntryW-1];
    end

    ring_d = '0;
    for (int unsigned k = 0; k < Depth - 1; k++) begin
      ring_d[k] = ring_q[k+1];
    end
    // After this edge the ring has advanced one step, so latency L lands at index L-1.
    for (int unsigned k = 0; k < Depth; k++) begin
      if (push && (32'(lat) == k + 1)) ring_d[k] = push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ring_q <= '0;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign head = ring_q[0];

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: scoreboard of in-flight destinations, decode stall and writeback ownership
// for the ALU and multiply pipes sharing one register-file write port.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned ALU_LAT  = AluLatDef,
  parameter int unsigned MUL_LAT  = MulLatDef,
  parameter int unsigned REG_ADDR = RegAddrDef,
  parameter int unsigned CNT_W    = CntWDef
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec_valid,
  input  logic [REG_ADDR-1:0]    dec_src1,
  input  logic [REG_ADDR-1:0]    dec_src2,
  input  logic                   dec_use_src2,
  input  logic [REG_ADDR-1:0]    dec_dst,
  input  logic                   dec_regwrite,
  input  logic                   dec_is_mult,
  output logic                   stall,
  output logic                   issue,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   wb_valid,
  output logic [REG_ADDR-1:0]    wb_dst,
  output logic                   wb_from_mult,
  output logic [2**REG_ADDR-1:0] busy_vec,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR;
  localparam int unsigned EntryW  = ring_entry_w(REG_ADDR);

  logic [NumRegs-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               reserve, raw_hazard, waw_hazard, slot_taken, push;
  logic [LatW-1:0]    lat;
  logic [EntryW-1:0]  push_entry, head_entry;

  // Writes to r0 are discarded, so they never claim the port or a busy bit.
  assign reserve    = dec_regwrite && (dec_dst != '0);
  assign lat        = dec_is_mult ? LatW'(MUL_LAT) : LatW'(ALU_LAT);
  assign raw_hazard = ((dec_src1 != '0) && busy_q[dec_src1]) ||
                      (dec_use_src2 && (dec_src2 != '0) && busy_q[dec_src2]);
  assign waw_hazard = reserve && busy_q[dec_dst];

  assign stall       = dec_valid && (raw_hazard || waw_hazard || (reserve && slot_taken));
  assign issue       = dec_valid && !stall;
  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign push        = issue && reserve;
  assign push_entry  = {1'b1, dec_dst, dec_is_mult};

  wb_reservation_ring #(
    .Depth  (MUL_LAT),
    .EntryW (EntryW)
  ) u_ring (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .lat        (lat),
    .push_entry (push_entry),
    .occupied   (slot_taken),
    .head       (head_entry)
  );

  assign wb_valid     = head_entry[EntryW-1];
  assign wb_dst       = head_entry[EntryW-2:1];
  assign wb_from_mult = head_entry[0];

  always_comb begin
    busy_d = busy_q;
    // Retire before set, so a same-register set wins.
    if (wb_valid) busy_d[wb_dst] = 1'b0;
    if (push) busy_d[dec_dst] = 1'b1;

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q        <= '0;
      stall_count_q <= '0;
    end else begin
      busy_q        <= busy_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign busy_vec    = busy_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus random traffic checked
// against a list-of-pending-writes reference model.
module tb_issue_scoreboard;

  localparam int AluLat = 3;
  localparam int MulLat = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_src1, dec_src2, dec_dst;
  logic        dec_use_src2, dec_regwrite, dec_is_mult;
  logic        stall, issue, pc_write, if_id_write;
  logic        wb_valid, wb_from_mult;
  logic [4:0]  wb_dst;
  logic [31:0] busy_vec;
  logic [15:0] stall_count;

  issue_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_src1     (dec_src1),
    .dec_src2     (dec_src2),
    .dec_use_src2 (dec_use_src2),
    .dec_dst      (dec_dst),
    .dec_regwrite (dec_regwrite),
    .dec_is_mult  (dec_is_mult),
    .stall        (stall),
    .issue        (issue),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .wb_valid     (wb_valid),
    .wb_dst       (wb_dst),
    .wb_from_mult (wb_from_mult),
    .busy_vec     (busy_vec),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: each pending write is just "register dst is written in cycle retire".
  typedef struct {
    int         retire;
    logic [4:0] dst;
    logic       mult;
  } pend_t;

  pend_t       pend[$];
  int          t;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_cnt;

  logic        obs_issue, obs_pcw, obs_wb_valid, obs_wb_from_mult;
  logic [4:0]  obs_wb_dst;
  logic [31:0] obs_busy;
  logic [15:0] obs_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u2, input logic [4:0] d, input logic rw, input logic m,
                      input logic rst);
    logic [31:0] e_busy;
    logic        e_wbv, e_wbm, e_stall, resv, taken;
    logic [4:0]  e_wbd;
    int          lat;
    pend_t       p;
    dec_valid = v; dec_src1 = s1; dec_src2 = s2; dec_use_src2 = u2;
    dec_dst = d; dec_regwrite = rw; dec_is_mult = m; reset = rst;
    @(negedge clk);
    e_busy = '0; e_wbv = 1'b0; e_wbd = '0; e_wbm = 1'b0; taken = 1'b0;
    lat  = m ? MulLat : AluLat;
    resv = rw && (d != 5'd0);
    foreach (pend[i]) begin
      e_busy[pend[i].dst] = 1'b1;
      if (pend[i].retire == t) begin
        e_wbv = 1'b1; e_wbd = pend[i].dst; e_wbm = pend[i].mult;
      end
      if (pend[i].retire == t + lat) taken = 1'b1;
    end
    e_stall = v && (((s1 != 5'd0) && e_busy[s1]) || (u2 && (s2 != 5'd0) && e_busy[s2]) ||
                    (resv && (e_busy[d] || taken)));

    obs_issue = issue; obs_pcw = pc_write; obs_wb_valid = wb_valid; obs_wb_dst = wb_dst;
    obs_wb_from_mult = wb_from_mult; obs_busy = busy_vec; obs_cnt = stall_count;

    chk("stall", stall, e_stall);
    chk("issue", issue, v && !e_stall);
    chk("pc_write", pc_write, !e_stall);
    chk("if_id_write", if_id_write, !e_stall);
    chk("wb_valid", wb_valid, e_wbv);
    if (e_wbv) begin
      chk("wb_dst", wb_dst, e_wbd);
      chk("wb_from_mult", wb_from_mult, e_wbm);
    end
    chk("busy_vec", busy_vec, e_busy);
    chk("stall_count", stall_count, m_cnt);

    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].retire == t) pend.delete(i);
    end
    if (rst) begin
      pend.delete();
      m_cnt = '0;
    end else begin
      if (v && !e_stall && resv) begin
        p.retire = t + lat; p.dst = d; p.mult = m;
        pend.push_back(p);
      end
      if (v && e_stall && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rst_step();
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    t = 0;
    m_cnt = '0;
    dec_valid = 1'b0; dec_src1 = '0; dec_src2 = '0; dec_use_src2 = 1'b0;
    dec_dst = '0; dec_regwrite = 1'b0; dec_is_mult = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and ALU writeback timing.
    rst_step();
    step(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      nop();
      chk("t1_busy3", obs_busy[3], c <= 3);
      if (c == 3) begin
        chk("t1_wb_valid", obs_wb_valid, 1'b1);
        chk("t1_wb_dst", obs_wb_dst, 5'd3);
        chk("t1_wb_mult", obs_wb_from_mult, 1'b0);
      end
    end

    // RAW on a multiply result.
    rst_step();
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      step(1'b1, 5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      chk("t2_issue", obs_issue, c == 7);
      chk("t2_pc_write", obs_pcw, c == 7);
    end
    chk("t2_stall_count", obs_cnt, 16'd6);

    // Structural conflict on the write port.
    rst_step();
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    nop();
    nop();
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("t3_issue_c3", obs_issue, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("t3_issue_c4", obs_issue, 1'b1);
    nop();
    nop();
    chk("t3_wb6_valid", obs_wb_valid, 1'b1);
    chk("t3_wb6_dst", obs_wb_dst, 5'd5);
    chk("t3_wb6_mult", obs_wb_from_mult, 1'b1);
    nop();
    chk("t3_wb7_valid", obs_wb_valid, 1'b1);
    chk("t3_wb7_dst", obs_wb_dst, 5'd7);
    chk("t3_wb7_mult", obs_wb_from_mult, 1'b0);

    // Non-reserving ops back to back.
    rst_step();
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 5'd0, 5'd0, 1'b1, (c % 2 == 1) ? 5'($urandom_range(31, 1)) : 5'd0,
           c % 2 == 0, 1'($urandom_range(1)), 1'b0);
      chk("t4_issue", obs_issue, 1'b1);
      chk("t4_wb_valid", obs_wb_valid, 1'b0);
    end

    // WAW: ALU r4 then MUL r4.
    rst_step();
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      chk("t5_issue", obs_issue, c == 4);
    end
    for (int c = 5; c <= 10; c++) nop();
    chk("t5_wb_valid", obs_wb_valid, 1'b1);
    chk("t5_wb_dst", obs_wb_dst, 5'd4);
    chk("t5_wb_mult", obs_wb_from_mult, 1'b1);

    // Reset with a multiply in flight.
    rst_step();
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    nop();
    rst_step();
    for (int c = 3; c <= 9; c++) begin
      nop();
      chk("t6_wb_valid", obs_wb_valid, 1'b0);
      if (c == 3) chk("t6_busy", obs_busy, 32'd0);
    end

    // Stall counter saturation.
    rst_step();
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    dec_valid = 1'b1; dec_src1 = 5'd5; dec_use_src2 = 1'b0; dec_dst = 5'd6;
    dec_regwrite = 1'b1; dec_is_mult = 1'b0; reset = 1'b0;
    force dut.stall_count_q = 16'hFFFF;
    @(negedge clk);
    chk("sat_stall", stall, 1'b1);
    chk("sat_count", stall_count, 16'hFFFF);
    chk("sat_next", dut.stall_count_d, 16'hFFFF);
    release dut.stall_count_q;
    dec_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend.delete();
    m_cnt = '0;
    t++;

    // Random traffic on a narrow register range to provoke hazards.
    rst_step();
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(9) < 8, 5'($urandom_range(7)), 5'($urandom_range(7)),
           1'($urandom_range(1)), 5'($urandom_range(7)), $urandom_range(3) != 0,
           1'($urandom_range(1)), $urandom_range(99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
